alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

ID/EX pipeline stage that feeds the `alu` block. Each cycle it captures the decoded instruction fields and decodes them into an `alu_operation_e` value. It applies the EX-stage forwarding muxes and drives the ALU's `operand_a`, `operand_b` and `operation` inputs. It supports stall (hold) and flush (bubble insertion) for hazard control.

## Interface
Parameters:
- DW, 32, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_ready  out  1  stage accepts; equals !stall
- stall  in  1  hold all registered contents
- flush  in  1  insert bubble; priority over stall
- id_rs1_data, id_rs2_data  in  DW  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  RW  register indices
- id_alu_op  in  2  00 add, 01 sub, 10 R-type, 11 I-type
- id_funct3  in  3  instruction funct3
- id_funct7_5  in  1  instruction bit 30
- id_alu_src  in  1  1 selects immediate for operand_b
- id_reg_write  in  1  instruction writes rd
- mem_rd, wb_rd  in  RW  destinations in MEM and WB
- mem_reg_write, wb_reg_write  in  1  write enables for MEM and WB
- mem_result, wb_result  in  DW  forwardable values
- ex_valid  out  1  EX holds a valid instruction
- operand_a, operand_b  out  DW  ALU operands
- operation  out  alu_operation_e  ALU operation
- ex_rd  out  RW  registered destination
- ex_reg_write  out  1  registered write enable, gated by ex_valid
- ex_illegal  out  1  unsupported funct3 decode in EX

## Operation
- Decode in ID, registered into EX:
  - alu_op 00 -> ALU_ADD
  - alu_op 01 -> ALU_SUB
  - alu_op 10:
    - funct3 000 with funct7_5=1 -> ALU_SUB
    - funct3 000 with funct7_5=0 -> ALU_ADD
    - funct3 111 -> ALU_AND
    - funct3 110 -> ALU_OR
  - alu_op 11: funct3 000 -> ALU_ADD (funct7_5 ignored); 111 -> ALU_AND; 110 -> ALU_OR
  - Any other alu_op 10/11 funct3 -> ALU_ADD with illegal=1
- Capture rules:
  - flush=1 -> ex_valid=0, ex_reg_write=0, ex_illegal=0; other fields don't-care
  - else stall=1 -> all registers hold
  - else load ID fields; ex_valid=id_valid
- Forwarding for rs1 and rs2, combinational from the registered index:
  - Source is mem_result if mem_reg_write, mem_rd==rs and rs!=0
  - else wb_result if wb_reg_write, wb_rd==rs and rs!=0
  - else the registered register-file data
  - MEM has priority over WB
  - x0 is never forwarded
- operand_a is the forwarded rs1.
- operand_b is the registered imm if alu_src=1, otherwise the forwarded rs2.
- ex_reg_write = registered reg_write & ex_valid.
- ex_illegal = registered illegal & ex_valid.

## Timing
- Latency is 1 cycle: ID fields present at edge N appear on the outputs after edge N.
- Forwarding adds no latency; it is a combinational path from mem_*/wb_* to operand_a/b.
- Reset (async assert, sync-to-edge deassert semantics handled by the core):
  - All registers clear: ex_valid=0, ex_rd=0, ex_reg_write=0, ex_illegal=0, operation=ALU_ADD.
  - Registered data and indices clear to 0, so operand_a=operand_b=0 unless MEM/WB forward x0, which is excluded.
- flush and stall asserted together: flush wins and a bubble is loaded.
- Reset mid-stall clears the stage; the held instruction is lost. The hazard unit must replay it.
- id_ready falls combinationally with stall; the ID stage must not advance while id_ready=0.

## Configuration
- ALU_ISSUE_FORWARDING_EN defined: forwarding muxes are as described above.
- ALU_ISSUE_FORWARDING_EN undefined:
  - operands come directly from the registered register-file data and imm.
  - mem_*/wb_* inputs remain on the port list but are ignored.
  - The hazard unit must stall on RAW dependences.

## Structure
- riscv_package gains:
  - alu_op_e (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_ITYPE)
  - funct3 constants F3_ADD=3'b000, F3_OR=3'b110, F3_AND=3'b111
  - fwd_sel_e (FWD_RF, FWD_MEM, FWD_WB)
- One sub-module, alu_controller: combinational decode of alu_op/funct3/funct7_5 to {alu_operation_e, illegal}, instantiated before the pipeline register.
- Forwarding selection stays inline.

## Test plan
- R-type funct3=000, funct7_5=1, rs1_data=10, rs2_data=3, no hazards -> next cycle operation=ALU_SUB, operand_a=10, operand_b=3, ex_valid=1.
- I-type funct3=111, imm=0x0F, alu_src=1 -> operation=ALU_AND, operand_b=0x0F.
- EX rs1=5 with mem_rd=5 (mem_result=0xAA) and wb_rd=5 (wb_result=0xBB), both writing -> operand_a=0xAA. Repeat with rs1=0 -> operand_a = registered data.
- stall held 3 cycles while ID changes -> outputs constant. flush+stall together -> ex_valid=0, ex_reg_write=0 next cycle.
- alu_op=10, funct3=001 -> operation=ALU_ADD, ex_illegal=1. Then flush -> ex_illegal=0.
- Assert reset asynchronously mid-cycle -> all outputs take reset values immediately without a clock edge.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
// Shared types and constants for the ID/EX issue stage that feeds the ALU.
//   alu_operation_e : operation encoding consumed by the alu block
//   alu_op_e        : coarse ALU op class produced by the main decoder
//   F3_*            : funct3 values recognised by the ALU controller
//   fwd_sel_e       : operand source select for the EX forwarding muxes
package alu_issue_stage_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_operation_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } alu_op_e;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/alu_issue_stage_alu_controller.sv
// alu_controller
// Combinational decode of the main-decoder ALU op class plus funct3/funct7[5]
// into the ALU operation. Unsupported funct3 values for R/I-type decode to
// ALU_ADD and raise illegal.
// Ports:
//   alu_op    in  2  op class (alu_op_e encoding)
//   funct3    in  3  instruction funct3
//   funct7_5  in  1  instruction bit 30 (R-type add/sub select)
//   operation out    decoded alu_operation_e
//   illegal   out 1  unsupported funct3
module alu_controller
    import alu_issue_stage_pkg::*;
(
    input  logic [1:0]     alu_op,
    input  logic [2:0]     funct3,
    input  logic           funct7_5,
    output alu_operation_e operation,
    output logic           illegal
);

    always_comb begin
        operation = ALU_ADD;
        illegal   = 1'b0;
        unique case (alu_op_e'(alu_op))
            ALUOP_ADD: operation = ALU_ADD;
            ALUOP_SUB: operation = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct3)
                    F3_ADD:  operation = funct7_5 ? ALU_SUB : ALU_ADD;
                    F3_AND:  operation = ALU_AND;
                    F3_OR:   operation = ALU_OR;
                    default: illegal   = 1'b1;
                endcase
            end
            ALUOP_ITYPE: begin
                // funct7[5] is part of the immediate for I-type, so it is ignored
                case (funct3)
                    F3_ADD:  operation = ALU_ADD;
                    F3_AND:  operation = ALU_AND;
                    F3_OR:   operation = ALU_OR;
                    default: illegal   = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ID/EX pipeline register feeding the ALU. Decodes the ALU operation in ID,
// registers instruction fields, and drives operand_a/operand_b/operation.
// stall holds every register; flush loads a bubble and wins over stall.
// Optional feature macro: ALU_ISSUE_FORWARDING_EN
//   defined   : MEM/WB results forwarded into the operands (MEM first, x0 never)
//   undefined : operands come straight from registered RF data / imm and the
//               mem_*/wb_* inputs are ignored
// Ports:
//   clk, reset (async, active-high)
//   id_valid, id_ready (= !stall), stall, flush
//   id_rs1_data, id_rs2_data, id_imm        ID data
//   id_rs1, id_rs2, id_rd                   ID register indices
//   id_alu_op, id_funct3, id_funct7_5       decode inputs
//   id_alu_src, id_reg_write                ID control
//   mem_rd/wb_rd, mem_reg_write/wb_reg_write, mem_result/wb_result  forwarding sources
//   ex_valid, operand_a, operand_b, operation, ex_rd, ex_reg_write, ex_illegal
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           id_valid,
    output logic           id_ready,
    input  logic           stall,
    input  logic           flush,
    input  logic [DW-1:0]  id_rs1_data,
    input  logic [DW-1:0]  id_rs2_data,
    input  logic [DW-1:0]  id_imm,
    input  logic [RW-1:0]  id_rs1,
    input  logic [RW-1:0]  id_rs2,
    input  logic [RW-1:0]  id_rd,
    input  logic [1:0]     id_alu_op,
    input  logic [2:0]     id_funct3,
    input  logic           id_funct7_5,
    input  logic           id_alu_src,
    input  logic           id_reg_write,
    input  logic [RW-1:0]  mem_rd,
    input  logic [RW-1:0]  wb_rd,
    input  logic           mem_reg_write,
    input  logic           wb_reg_write,
    input  logic [DW-1:0]  mem_result,
    input  logic [DW-1:0]  wb_result,
    output logic           ex_valid,
    output logic [DW-1:0]  operand_a,
    output logic [DW-1:0]  operand_b,
    output alu_operation_e operation,
    output logic [RW-1:0]  ex_rd,
    output logic           ex_reg_write,
    output logic           ex_illegal
);

    alu_operation_e id_operation;
    logic           id_illegal;

    logic [DW-1:0]  rs1_data_q;
    logic [DW-1:0]  rs2_data_q;
    logic [DW-1:0]  imm_q;
    logic [RW-1:0]  rs1_q;
    logic [RW-1:0]  rs2_q;
    logic           alu_src_q;
    logic           reg_write_q;
    logic           illegal_q;
    logic [DW-1:0]  fwd_a;
    logic [DW-1:0]  fwd_b;

    alu_controller u_alu_controller (
        .alu_op    (id_alu_op),
        .funct3    (id_funct3),
        .funct7_5  (id_funct7_5),
        .operation (id_operation),
        .illegal   (id_illegal)
    );

    assign id_ready = ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            operation   <= ALU_ADD;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            alu_src_q   <= 1'b0;
        end else if (flush) begin
            // Bubble: only the qualifying bits are cleared, datapath fields hold
            ex_valid    <= 1'b0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (!stall) begin
            ex_valid    <= id_valid;
            ex_rd       <= id_rd;
            reg_write_q <= id_reg_write;
            illegal_q   <= id_illegal;
            operation   <= id_operation;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            alu_src_q   <= id_alu_src;
        end
    end

`ifdef ALU_ISSUE_FORWARDING_EN
    fwd_sel_e sel_a;
    fwd_sel_e sel_b;

    always_comb begin
        sel_a = FWD_RF;
        if (mem_reg_write && (mem_rd == rs1_q) && (rs1_q != '0))
            sel_a = FWD_MEM;
        else if (wb_reg_write && (wb_rd == rs1_q) && (rs1_q != '0))
            sel_a = FWD_WB;

        sel_b = FWD_RF;
        if (mem_reg_write && (mem_rd == rs2_q) && (rs2_q != '0))
            sel_b = FWD_MEM;
        else if (wb_reg_write && (wb_rd == rs2_q) && (rs2_q != '0))
            sel_b = FWD_WB;
    end

    always_comb begin
        case (sel_a)
            FWD_MEM: fwd_a = mem_result;
            FWD_WB:  fwd_a = wb_result;
            default: fwd_a = rs1_data_q;
        endcase
        case (sel_b)
            FWD_MEM: fwd_b = mem_result;
            FWD_WB:  fwd_b = wb_result;
            default: fwd_b = rs2_data_q;
        endcase
    end
`else
    logic unused_fwd;

    assign fwd_a = rs1_data_q;
    assign fwd_b = rs2_data_q;
    // Forwarding sources stay on the port list for drop-in compatibility
    assign unused_fwd = ^{mem_rd, wb_rd, mem_reg_write, wb_reg_write,
                          mem_result, wb_result, rs1_q, rs2_q};
`endif

    assign operand_a    = fwd_a;
    assign operand_b    = alu_src_q ? imm_q : fwd_b;
    assign ex_reg_write = reg_write_q & ex_valid;
    assign ex_illegal   = illegal_q & ex_valid;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic           id_valid;
    logic           id_ready;
    logic           stall;
    logic           flush;
    logic [31:0]    id_rs1_data;
    logic [31:0]    id_rs2_data;
    logic [31:0]    id_imm;
    logic [4:0]     id_rs1;
    logic [4:0]     id_rs2;
    logic [4:0]     id_rd;
    logic [1:0]     id_alu_op;
    logic [2:0]     id_funct3;
    logic           id_funct7_5;
    logic           id_alu_src;
    logic           id_reg_write;
    logic [4:0]     mem_rd;
    logic [4:0]     wb_rd;
    logic           mem_reg_write;
    logic           wb_reg_write;
    logic [31:0]    mem_result;
    logic [31:0]    wb_result;
    logic           ex_valid;
    logic [31:0]    operand_a;
    logic [31:0]    operand_b;
    alu_operation_e operation;
    logic [4:0]     ex_rd;
    logic           ex_reg_write;
    logic           ex_illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DW(32), .RW(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .stall         (stall),
        .flush         (flush),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_alu_op     (id_alu_op),
        .id_funct3     (id_funct3),
        .id_funct7_5   (id_funct7_5),
        .id_alu_src    (id_alu_src),
        .id_reg_write  (id_reg_write),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .mem_result    (mem_result),
        .wb_result     (wb_result),
        .ex_valid      (ex_valid),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .operation     (operation),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_illegal    (ex_illegal)
    );

    typedef struct {
        logic           v;
        logic [1:0]     op;
        logic [2:0]     f3;
        logic           f7;
        logic           src;
        logic           rw;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [4:0]     rd;
        logic [31:0]    d1;
        logic [31:0]    d2;
        logic [31:0]    imm;
        logic [4:0]     mrd;
        logic           mwe;
        logic [31:0]    mres;
        logic [4:0]     wrd;
        logic           wwe;
        logic [31:0]    wres;
        alu_operation_e e_op;
        logic [31:0]    e_a_fwd;
        logic [31:0]    e_a_rf;
        logic [31:0]    e_b_fwd;
        logic [31:0]    e_b_rf;
        logic           e_v;
        logic           e_rw;
        logic           e_ill;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid      = t.v;
        id_alu_op     = t.op;
        id_funct3     = t.f3;
        id_funct7_5   = t.f7;
        id_alu_src    = t.src;
        id_reg_write  = t.rw;
        id_rs1        = t.rs1;
        id_rs2        = t.rs2;
        id_rd         = t.rd;
        id_rs1_data   = t.d1;
        id_rs2_data   = t.d2;
        id_imm        = t.imm;
        mem_rd        = t.mrd;
        mem_reg_write = t.mwe;
        mem_result    = t.mres;
        wb_rd         = t.wrd;
        wb_reg_write  = t.wwe;
        wb_result     = t.wres;
    endtask

    task automatic check_vec(input string tag, input vec_t t);
        logic [31:0] ea;
        logic [31:0] eb;
`ifdef ALU_ISSUE_FORWARDING_EN
        ea = t.e_a_fwd;
        eb = t.e_b_fwd;
`else
        ea = t.e_a_rf;
        eb = t.e_b_rf;
`endif
        chk({tag, "_operation"}, 32'(operation), 32'(t.e_op));
        chk({tag, "_operand_a"}, operand_a, ea);
        chk({tag, "_operand_b"}, operand_b, eb);
        chk({tag, "_ex_valid"}, 32'(ex_valid), 32'(t.e_v));
        chk({tag, "_ex_reg_write"}, 32'(ex_reg_write), 32'(t.e_rw));
        chk({tag, "_ex_illegal"}, 32'(ex_illegal), 32'(t.e_ill));
        chk({tag, "_ex_rd"}, 32'(ex_rd), 32'(t.rd));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_ex_rd"}, 32'(ex_rd), 32'd0);
        chk({tag, "_ex_reg_write"}, 32'(ex_reg_write), 32'd0);
        chk({tag, "_ex_illegal"}, 32'(ex_illegal), 32'd0);
        chk({tag, "_operation"}, 32'(operation), 32'(ALU_ADD));
        chk({tag, "_operand_a"}, operand_a, 32'd0);
        chk({tag, "_operand_b"}, operand_b, 32'd0);
    endtask

    initial begin
        //           v  op     f3      f7 src rw rs1 rs2 rd d1          d2          imm            mrd mwe mres   wrd wwe wres   e_op     a_fwd       a_rf        b_fwd       b_rf        ev erw eil
        vecs[0]  = '{1, 2'b10, 3'b000, 1, 0, 1, 1,  2,  3, 32'd10,     32'd3,      32'd0,         0,  0,  32'h0, 0,  0,  32'h0, ALU_SUB, 32'd10,     32'd10,     32'd3,      32'd3,      1, 1, 0};
        vecs[1]  = '{1, 2'b10, 3'b000, 0, 0, 1, 4,  5,  6, 32'd7,      32'd8,      32'd0,         0,  0,  32'h0, 0,  0,  32'h0, ALU_ADD, 32'd7,      32'd7,      32'd8,      32'd8,      1, 1, 0};
        vecs[2]  = '{1, 2'b10, 3'b111, 0, 0, 1, 1,  2,  9, 32'hF0F0,   32'h0FF0,   32'd0,         0,  0,  32'h0, 0,  0,  32'h0, ALU_AND, 32'hF0F0,   32'hF0F0,   32'h0FF0,   32'h0FF0,   1, 1, 0};
        vecs[3]  = '{1, 2'b10, 3'b110, 1, 0, 1, 1,  2, 10, 32'h1,      32'h2,      32'd0,         0,  0,  32'h0, 0,  0,  32'h0, ALU_OR,  32'h1,      32'h1,      32'h2,      32'h2,      1, 1, 0};
        vecs[4]  = '{1, 2'b11, 3'b111, 0, 1, 1, 1,  2,  4, 32'h1234,   32'h55,     32'h0F,        0,  0,  32'h0, 0,  0,  32'h0, ALU_AND, 32'h1234,   32'h1234,   32'h0F,     32'h0F,     1, 1, 0};
        vecs[5]  = '{1, 2'b11, 3'b000, 1, 1, 0, 3,  4,  5, 32'd100,    32'd200,    32'hFFFFFFFF,  0,  0,  32'h0, 0,  0,  32'h0, ALU_ADD, 32'd100,    32'd100,    32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0};
        vecs[6]  = '{1, 2'b00, 3'b101, 1, 0, 1, 1,  2,  7, 32'd5,      32'd6,      32'd0,         0,  0,  32'h0, 0,  0,  32'h0, ALU_ADD, 32'd5,      32'd5,      32'd6,      32'd6,      1, 1, 0};
        vecs[7]  = '{1, 2'b01, 3'b111, 0, 0, 1, 1,  2,  8, 32'd9,      32'd4,      32'd0,         0,  0,  32'h0, 0,  0,  32'h0, ALU_SUB, 32'd9,      32'd9,      32'd4,      32'd4,      1, 1, 0};
        vecs[8]  = '{1, 2'b00, 3'b000, 0, 0, 1, 5,  2,  1, 32'h11,     32'h22,     32'd0,         5,  1,  32'hAA,5,  1,  32'hBB,ALU_ADD, 32'hAA,     32'h11,     32'h22,     32'h22,     1, 1, 0};
        vecs[9]  = '{1, 2'b00, 3'b000, 0, 0, 1, 0,  3,  2, 32'h22,     32'h44,     32'd0,         0,  1,  32'hAA,0,  1,  32'hBB,ALU_ADD, 32'h22,     32'h22,     32'h44,     32'h44,     1, 1, 0};
        vecs[10] = '{1, 2'b01, 3'b000, 0, 0, 1, 1,  6, 11, 32'h1,      32'h33,     32'd0,         7,  1,  32'hAA,6,  1,  32'hCC,ALU_SUB, 32'h1,      32'h1,      32'hCC,     32'h33,     1, 1, 0};
        vecs[11] = '{1, 2'b11, 3'b110, 0, 1, 1, 8,  9, 12, 32'h77,     32'h88,     32'h5,         8,  0,  32'hAA,9,  1,  32'hBB,ALU_OR,  32'h77,     32'h77,     32'h5,      32'h5,      1, 1, 0};
        vecs[12] = '{1, 2'b10, 3'b001, 0, 0, 1, 1,  2, 13, 32'h3,      32'h4,      32'd0,         0,  0,  32'h0, 0,  0,  32'h0, ALU_ADD, 32'h3,      32'h3,      32'h4,      32'h4,      1, 1, 1};
        vecs[13] = '{0, 2'b11, 3'b010, 0, 0, 1, 1,  2, 14, 32'h6,      32'h7,      32'd0,         0,  0,  32'h0, 0,  0,  32'h0, ALU_ADD, 32'h6,      32'h6,      32'h7,      32'h7,      0, 0, 0};

        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive('{0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0,
                ALU_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0});
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        chk("reset_id_ready", 32'(id_ready), 32'd1);
        reset = 1'b0;

        // Table: one instruction per cycle, checked just after the capturing edge
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Stall for 3 cycles while ID keeps changing: EX must hold vec0
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk);
        #1;
        check_vec("stall_load", vecs[0]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stall = 1'b1;
            drive(vecs[k + 1]);
            mem_reg_write = 1'b0;
            wb_reg_write  = 1'b0;
            #1;
            chk($sformatf("stall%0d_id_ready", k), 32'(id_ready), 32'd0);
            @(posedge clk);
            #1;
            check_vec($sformatf("stall%0d", k), vecs[0]);
        end

        // flush and stall together: bubble wins
        @(negedge clk);
        flush = 1'b1;
        stall = 1'b1;
        drive(vecs[1]);
        @(posedge clk);
        #1;
        chk("flushstall_ex_valid", 32'(ex_valid), 32'd0);
        chk("flushstall_ex_reg_write", 32'(ex_reg_write), 32'd0);
        chk("flushstall_ex_illegal", 32'(ex_illegal), 32'd0);

        // Illegal decode then flush clears ex_illegal
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
        drive(vecs[12]);
        @(posedge clk);
        #1;
        chk("illegal_ex_illegal", 32'(ex_illegal), 32'd1);
        chk("illegal_operation", 32'(operation), 32'(ALU_ADD));
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("illflush_ex_illegal", 32'(ex_illegal), 32'd0);
        chk("illflush_ex_valid", 32'(ex_valid), 32'd0);

        // Asynchronous reset mid-cycle, no clock edge in between
        @(negedge clk);
        flush = 1'b0;
        drive(vecs[0]);
        @(posedge clk);
        #1;
        chk("prereset_ex_valid", 32'(ex_valid), 32'd1);
        drive(vecs[13]);
        mem_reg_write = 1'b1;
        mem_rd        = 5'd0;
        mem_result    = 32'hDEAD;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
